// File: rtl/block_sync_lock_controller.sv
// Bring-up sequencer for the RX block-sync array and the AM-lock stage.
// It runs the lanes through lock, restarts them on timeout, and counts restarts and lock losses.
module block_sync_lock_controller #(
    parameter int N_LANES        = 20,
    parameter int NB_TIMER       = 16,
    parameter int RESTART_CYCLES = 4,
    parameter int NB_CNT         = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_signal_ok,
    input  logic [N_LANES-1:0]  i_block_lock,
    input  logic [N_LANES-1:0]  i_am_lock,
    input  logic [NB_TIMER-1:0] i_rf_timeout_limit,
    input  logic                i_rf_clear_counters,
    output logic                o_blksync_enable,
    output logic                o_blksync_restart,
    output logic                o_am_enable,
    output logic                o_all_block_lock,
    output logic                o_link_up,
    output logic [NB_CNT-1:0]   o_restart_count,
    output logic [NB_CNT-1:0]   o_lock_loss_count,
    output logic [2:0]          o_state
);

    localparam int NB_RC = $clog2(RESTART_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC_WAIT = 3'd1,
        RESTART   = 3'd2,
        AM_WAIT   = 3'd3,
        LINK_UP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NB_TIMER-1:0] timer_q, timer_d;
    logic [NB_RC-1:0]    restart_cnt_q, restart_cnt_d;
    logic [NB_CNT-1:0]   restart_count_q, restart_count_d;
    logic [NB_CNT-1:0]   lock_loss_count_q, lock_loss_count_d;
    logic                all_block_lock_q, all_block_lock_d;

    logic all_lock;
    logic all_am;
    logic timeout;
    logic in_wait;
    logic enter_restart;
    logic lock_loss;

    assign all_lock = &i_block_lock;
    assign all_am   = &i_am_lock;
    assign in_wait  = (state_q == SYNC_WAIT) || (state_q == AM_WAIT);
    // The limit is compared live, so a lowered limit only fires again after the timer wraps.
    assign timeout  = (i_rf_timeout_limit != '0) && (timer_q == i_rf_timeout_limit) && i_valid;

    always_comb begin
        state_d = state_q;
        if (!i_signal_ok) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC_WAIT;
                SYNC_WAIT: begin
                    if (all_lock)     state_d = AM_WAIT;
                    else if (timeout) state_d = RESTART;
                end
                RESTART: begin
                    if (restart_cnt_q == NB_RC'(RESTART_CYCLES - 1)) state_d = SYNC_WAIT;
                end
                AM_WAIT: begin
                    if (!all_lock)    state_d = SYNC_WAIT;
                    else if (all_am)  state_d = LINK_UP;
                    else if (timeout) state_d = RESTART;
                end
                LINK_UP: begin
                    if (!all_lock)    state_d = SYNC_WAIT;
                    else if (!all_am) state_d = AM_WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign enter_restart = (state_d == RESTART) && (state_q != RESTART);
    assign lock_loss     = (state_q == LINK_UP) && (state_d == SYNC_WAIT);

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (in_wait && i_valid) begin
            timer_d = timer_q + NB_TIMER'(1);
        end

        restart_cnt_d = '0;
        if ((state_q == RESTART) && (state_d == RESTART)) begin
            restart_cnt_d = restart_cnt_q + NB_RC'(1);
        end

        restart_count_d = restart_count_q;
        if (i_rf_clear_counters) begin
            restart_count_d = '0;
        end else if (enter_restart && (restart_count_q != '1)) begin
            restart_count_d = restart_count_q + NB_CNT'(1);
        end

        lock_loss_count_d = lock_loss_count_q;
        if (i_rf_clear_counters) begin
            lock_loss_count_d = '0;
        end else if (lock_loss && (lock_loss_count_q != '1)) begin
            lock_loss_count_d = lock_loss_count_q + NB_CNT'(1);
        end

        all_block_lock_d = all_lock;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q           <= IDLE;
            timer_q           <= '0;
            restart_cnt_q     <= '0;
            restart_count_q   <= '0;
            lock_loss_count_q <= '0;
            all_block_lock_q  <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            restart_cnt_q     <= restart_cnt_d;
            restart_count_q   <= restart_count_d;
            lock_loss_count_q <= lock_loss_count_d;
            all_block_lock_q  <= all_block_lock_d;
        end
    end

    always_comb begin
        o_blksync_enable  = (state_q == SYNC_WAIT) || (state_q == AM_WAIT) || (state_q == LINK_UP);
        o_blksync_restart = (state_q == RESTART);
        o_am_enable       = (state_q == AM_WAIT) || (state_q == LINK_UP);
        o_link_up         = (state_q == LINK_UP);
        o_all_block_lock  = all_block_lock_q;
        o_restart_count   = restart_count_q;
        o_lock_loss_count = lock_loss_count_q;
        o_state           = state_q;
    end

endmodule

// File: tb/tb_block_sync_lock_controller.sv
// Directed bench for block_sync_lock_controller: bring-up, lock loss, timeouts, restarts and counters.
module tb_block_sync_lock_controller;

    localparam int N_LANES = 20;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_signal_ok = 1'b0;
    logic [19:0] i_block_lock = '0;
    logic [19:0] i_am_lock = '0;
    logic [15:0] i_rf_timeout_limit = '0;
    logic        i_rf_clear_counters = 1'b0;
    logic        o_blksync_enable;
    logic        o_blksync_restart;
    logic        o_am_enable;
    logic        o_all_block_lock;
    logic        o_link_up;
    logic [7:0]  o_restart_count;
    logic [7:0]  o_lock_loss_count;
    logic [2:0]  o_state;

    int checks = 0;
    int failures = 0;

    block_sync_lock_controller #(
        .N_LANES(N_LANES), .NB_TIMER(16), .RESTART_CYCLES(4), .NB_CNT(8)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .i_signal_ok(i_signal_ok),
        .i_block_lock(i_block_lock),
        .i_am_lock(i_am_lock),
        .i_rf_timeout_limit(i_rf_timeout_limit),
        .i_rf_clear_counters(i_rf_clear_counters),
        .o_blksync_enable(o_blksync_enable),
        .o_blksync_restart(o_blksync_restart),
        .o_am_enable(o_am_enable),
        .o_all_block_lock(o_all_block_lock),
        .o_link_up(o_link_up),
        .o_restart_count(o_restart_count),
        .o_lock_loss_count(o_lock_loss_count),
        .o_state(o_state)
    );

    always #5 i_clock = ~i_clock;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic apply_reset();
        i_signal_ok = 1'b0;
        i_valid = 1'b1;
        i_block_lock = '0;
        i_am_lock = '0;
        i_rf_clear_counters = 1'b0;
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_signal_ok = 1'b1;
        i_valid = 1'b1;
        i_block_lock = '1;
        i_reset = 1'b1;
        step();
        step();
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if ({o_blksync_enable, o_blksync_restart, o_am_enable, o_link_up, o_all_block_lock} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=00000", {o_blksync_enable, o_blksync_restart, o_am_enable, o_link_up, o_all_block_lock}); end
        checks++; if ({o_restart_count, o_lock_loss_count} !== 16'h0) begin
            failures++; $display("FAIL reset_counts got=%h exp=0000", {o_restart_count, o_lock_loss_count}); end
        i_reset = 1'b0;
        $display("test_reset done: state=%0d", o_state);
    endtask

    task automatic test_link_up();
        apply_reset();
        i_rf_timeout_limit = 16'd100;
        i_signal_ok = 1'b1;
        step();
        checks++; if (o_state !== 3'd1 || o_blksync_enable !== 1'b1 || o_am_enable !== 1'b0) begin
            failures++; $display("FAIL enter_sync_wait got state=%0d en=%b am=%b exp 1/1/0", o_state, o_blksync_enable, o_am_enable); end
        repeat (29) step();
        checks++; if (o_state !== 3'd1 || o_all_block_lock !== 1'b0) begin
            failures++; $display("FAIL still_sync_wait got state=%0d lock=%b exp 1/0", o_state, o_all_block_lock); end
        i_block_lock = '1;
        step();
        checks++; if (o_state !== 3'd3 || o_all_block_lock !== 1'b1 || o_am_enable !== 1'b1) begin
            failures++; $display("FAIL enter_am_wait got state=%0d lock=%b am=%b exp 3/1/1", o_state, o_all_block_lock, o_am_enable); end
        repeat (9) step();
        checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL hold_am_wait got=%0d exp=3", o_state); end
        i_am_lock = '1;
        step();
        checks++; if (o_state !== 3'd4 || o_link_up !== 1'b1 || o_restart_count !== 8'd0) begin
            failures++; $display("FAIL link_up got state=%0d up=%b rc=%0d exp 4/1/0", o_state, o_link_up, o_restart_count); end
        $display("test_link_up done: state=%0d link_up=%b", o_state, o_link_up);
    endtask

    task automatic test_lock_loss();
        i_block_lock[7] = 1'b0;
        step();
        checks++; if (o_state !== 3'd1 || o_lock_loss_count !== 8'd1 || o_am_enable !== 1'b0 || o_link_up !== 1'b0) begin
            failures++; $display("FAIL lock_loss got state=%0d ll=%0d am=%b up=%b exp 1/1/0/0", o_state, o_lock_loss_count, o_am_enable, o_link_up); end
        i_block_lock[7] = 1'b1;
        step();
        step();
        checks++; if (o_state !== 3'd4) begin failures++; $display("FAIL relock got=%0d exp=4", o_state); end
        $display("test_lock_loss done: lock_loss_count=%0d", o_lock_loss_count);
    endtask

    task automatic test_am_loss();
        i_am_lock[3] = 1'b0;
        step();
        checks++; if (o_state !== 3'd3 || o_blksync_enable !== 1'b1 || o_lock_loss_count !== 8'd1) begin
            failures++; $display("FAIL am_loss got state=%0d en=%b ll=%0d exp 3/1/1", o_state, o_blksync_enable, o_lock_loss_count); end
        i_am_lock[3] = 1'b1;
        step();
        checks++; if (o_state !== 3'd4) begin failures++; $display("FAIL am_relock got=%0d exp=4", o_state); end
        $display("test_am_loss done: state=%0d", o_state);
    endtask

    task automatic test_timeout_restart();
        int n;
        apply_reset();
        i_rf_timeout_limit = 16'd50;
        i_block_lock = 20'hFFFFE;
        i_signal_ok = 1'b1;
        step();
        repeat (50) step();
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL pre_timeout got=%0d exp=1", o_state); end
        step();
        checks++; if (o_state !== 3'd2 || o_blksync_restart !== 1'b1 || o_restart_count !== 8'd1) begin
            failures++; $display("FAIL timeout got state=%0d rst=%b rc=%0d exp 2/1/1", o_state, o_blksync_restart, o_restart_count); end
        n = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_blksync_restart === 1'b1) n++;
            else break;
        end
        checks++; if (n != 4 || o_state !== 3'd1) begin
            failures++; $display("FAIL restart_width got=%0d state=%0d exp 4/1", n, o_state); end
        repeat (50) step();
        checks++; if (o_state !== 3'd1 || o_restart_count !== 8'd1) begin
            failures++; $display("FAIL restart_period_pre got state=%0d rc=%0d exp 1/1", o_state, o_restart_count); end
        step();
        checks++; if (o_state !== 3'd2 || o_restart_count !== 8'd2) begin
            failures++; $display("FAIL restart_period got state=%0d rc=%0d exp 2/2", o_state, o_restart_count); end
        $display("test_timeout_restart done: restart_count=%0d", o_restart_count);
    endtask

    task automatic test_lock_vs_timeout();
        apply_reset();
        i_rf_timeout_limit = 16'd1;
        i_block_lock = 20'hFFFFE;
        i_signal_ok = 1'b1;
        step();
        step();
        i_block_lock = '1;
        step();
        checks++; if (o_state !== 3'd3 || o_restart_count !== 8'd0) begin
            failures++; $display("FAIL lock_beats_timeout got state=%0d rc=%0d exp 3/0", o_state, o_restart_count); end
        $display("test_lock_vs_timeout done: state=%0d", o_state);
    endtask

    task automatic test_signal_loss_in_restart();
        apply_reset();
        i_rf_timeout_limit = 16'd1;
        i_block_lock = 20'hFFFFE;
        i_signal_ok = 1'b1;
        step();
        step();
        step();
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL quick_restart got=%0d exp=2", o_state); end
        step();
        i_signal_ok = 1'b0;
        step();
        checks++; if (o_state !== 3'd0 || o_blksync_restart !== 1'b0 || o_blksync_enable !== 1'b0) begin
            failures++; $display("FAIL signal_loss got state=%0d rst=%b en=%b exp 0/0/0", o_state, o_blksync_restart, o_blksync_enable); end
        i_signal_ok = 1'b1;
        step();
        step();
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL timer_cleared_pre got=%0d exp=1", o_state); end
        step();
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL timer_cleared got=%0d exp=2", o_state); end
        $display("test_signal_loss_in_restart done: state=%0d", o_state);
    endtask

    task automatic test_limit_zero();
        apply_reset();
        i_rf_timeout_limit = 16'd0;
        i_block_lock = 20'hFFFFE;
        i_signal_ok = 1'b1;
        repeat (300) step();
        checks++; if (o_state !== 3'd1 || o_restart_count !== 8'd0) begin
            failures++; $display("FAIL limit_zero got state=%0d rc=%0d exp 1/0", o_state, o_restart_count); end
        $display("test_limit_zero done: restart_count=%0d", o_restart_count);
    endtask

    task automatic test_saturation();
        bit found;
        apply_reset();
        i_rf_timeout_limit = 16'd1;
        i_block_lock = 20'hFFFFE;
        i_signal_ok = 1'b1;
        repeat (300 * 6 + 20) step();
        checks++; if (o_restart_count !== 8'd255) begin
            failures++; $display("FAIL saturate got=%0d exp=255", o_restart_count); end
        for (int i = 0; i < 20 && o_state === 3'd2; i++) step();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_state === 3'd2) begin found = 1'b1; break; end
            step();
        end
        checks++; if (!found) begin failures++; $display("FAIL align_restart got state=%0d exp=2", o_state); end
        repeat (5) step();
        i_rf_clear_counters = 1'b1;
        step();
        i_rf_clear_counters = 1'b0;
        checks++; if (o_state !== 3'd2 || o_restart_count !== 8'd0) begin
            failures++; $display("FAIL clear_wins got state=%0d rc=%0d exp 2/0", o_state, o_restart_count); end
        repeat (6) step();
        checks++; if (o_state !== 3'd2 || o_restart_count !== 8'd1) begin
            failures++; $display("FAIL count_after_clear got state=%0d rc=%0d exp 2/1", o_state, o_restart_count); end
        step();
        i_reset = 1'b1;
        step();
        checks++; if (o_state !== 3'd0 || o_blksync_restart !== 1'b0 || o_restart_count !== 8'd0 || o_all_block_lock !== 1'b0) begin
            failures++; $display("FAIL reset_mid_restart got state=%0d rst=%b rc=%0d lock=%b exp 0/0/0/0", o_state, o_blksync_restart, o_restart_count, o_all_block_lock); end
        i_reset = 1'b0;
        $display("test_saturation done: restart_count=%0d", o_restart_count);
    endtask

    initial begin
        #2;
        test_reset();
        test_link_up();
        test_lock_loss();
        test_am_loss();
        test_timeout_restart();
        test_lock_vs_timeout();
        test_signal_loss_in_restart();
        test_limit_zero();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
